// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone memory arbiter.
//   arb_state_e  : arbiter FSM states (IDLE = no owner, OWNED = owner valid)
//   NUM_MASTERS  : number of requesting masters (fixed at 2)
//   M_INST       : index of the instruction-fetch master
//   M_DATA       : index of the data master
//   owner_index  : one-hot grant -> master index
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int M_INST      = 0;
    localparam int M_DATA      = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // With two masters the index of a one-hot grant is simply the data bit.
    function automatic logic owner_index(input logic [NUM_MASTERS-1:0] onehot);
        return onehot[M_DATA];
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// ---------------------------------------------------------------------------
// wb_arb_pick
// Purely combinational request picker.
//   req_i  : per-master request vector (master cycle lines)
//   last_i : index of the master granted most recently
//   gnt_o  : one-hot grant, all zero when nothing is requested
// A lone request is granted directly. On contention the master that was
// not granted most recently wins; holding last_i at M_INST therefore gives
// fixed priority to the data master.
// ---------------------------------------------------------------------------
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   last_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = '0;
            if (last_i == 1'(M_DATA)) begin
                gnt_o[M_INST] = 1'b1;
            end else begin
                gnt_o[M_DATA] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_mem_arbiter
// Arbitrates two Wishbone masters (0 = instruction fetch, 1 = data) onto a
// single main_memory slave port. Ownership is granted on a registered edge
// and held for as long as the owner keeps its cycle line high.
//
// Parameters
//   MEMORY_DEPTH : words in main_memory (AW = $clog2(MEMORY_DEPTH))
//   TIMEOUT      : max cycles a granted strobe may wait for ack
//
// Ports (master k owns slice [k*W +: W] of each master bus)
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_m_wb_cyc/stb/we [2]     : master cycle / strobe / write enable
//   i_m_wb_addr [2*AW]        : master addresses
//   i_m_wb_data [64]          : master write data
//   i_m_wb_sel  [8]           : master byte selects
//   o_m_wb_ack/stall [2]      : per-master ack / stall
//   o_m_wb_data [32]          : read data, broadcast to both masters
//   o_s_wb_*                  : slave-side request to main_memory
//   i_s_wb_ack/stall/data     : slave-side response from main_memory
//   o_grant [2]               : one-hot current owner, zero when idle
//   o_timeout                 : one-cycle pulse on forced release
//
// Build option
//   WB_ARB_ROUND_ROBIN_EN : contention goes to the master not granted most
//                           recently; otherwise the data master always wins.
// ---------------------------------------------------------------------------
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int MEMORY_DEPTH = 1024,
    parameter  int TIMEOUT      = 16,
    localparam int AW           = $clog2(MEMORY_DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic [1:0]      i_m_wb_cyc,
    input  logic [1:0]      i_m_wb_stb,
    input  logic [1:0]      i_m_wb_we,
    input  logic [2*AW-1:0] i_m_wb_addr,
    input  logic [63:0]     i_m_wb_data,
    input  logic [7:0]      i_m_wb_sel,
    output logic [1:0]      o_m_wb_ack,
    output logic [1:0]      o_m_wb_stall,
    output logic [31:0]     o_m_wb_data,

    output logic            o_s_wb_cyc,
    output logic            o_s_wb_stb,
    output logic            o_s_wb_we,
    output logic [AW-1:0]   o_s_wb_addr,
    output logic [31:0]     o_s_wb_data,
    output logic [3:0]      o_s_wb_sel,
    input  logic            i_s_wb_ack,
    input  logic            i_s_wb_stall,
    input  logic [31:0]     i_s_wb_data,

    output logic [1:0]      o_grant,
    output logic            o_timeout
);

    localparam int              CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [CW-1:0]          wait_q, wait_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_MASTERS-1:0] tack_q, tack_d;     // forced ack on timeout release

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   last_ptr;

    logic                   owned;
    logic                   own_idx;
    logic                   own_cyc;
    logic                   own_stb;

    // -----------------------------------------------------------------------
    // Contention pointer
    // -----------------------------------------------------------------------
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && |i_m_wb_cyc) begin
            last_d = owner_index(pick_gnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q <= 1'(M_INST);
        end else begin
            last_q <= last_d;
        end
    end

    assign last_ptr = last_q;
`else
    // "Master 0 granted last" forever makes the picker fixed-priority.
    assign last_ptr = 1'(M_INST);
`endif

    wb_arb_pick u_pick (
        .req_i  (i_m_wb_cyc),
        .last_i (last_ptr),
        .gnt_o  (pick_gnt)
    );

    // -----------------------------------------------------------------------
    // Owner decode
    // -----------------------------------------------------------------------
    assign owned   = (state_q == OWNED);
    assign own_idx = owner_index(grant_q);
    assign own_cyc = i_m_wb_cyc[own_idx];
    assign own_stb = i_m_wb_stb[own_idx];

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            tack_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            tack_q    <= tack_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        tack_d    = '0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (|i_m_wb_cyc) begin
                    state_d = OWNED;
                    grant_d = pick_gnt;
                end
            end

            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    wait_d  = '0;
                end else if (i_s_wb_ack) begin
                    wait_d = '0;
                end else if (own_stb) begin
                    if (wait_q == CNT_LAST) begin
                        // Give up on the slave: release the bus and fake an
                        // ack so the stuck master can finish its cycle.
                        state_d   = IDLE;
                        grant_d   = '0;
                        wait_d    = '0;
                        timeout_d = 1'b1;
                        tack_d    = grant_q;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                wait_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Slave-side request mux
    // -----------------------------------------------------------------------
    assign o_s_wb_cyc  = owned & own_cyc;
    assign o_s_wb_stb  = owned & own_stb;
    assign o_s_wb_we   = owned & i_m_wb_we[own_idx];
    assign o_s_wb_addr = own_idx ? i_m_wb_addr[2*AW-1:AW] : i_m_wb_addr[AW-1:0];
    assign o_s_wb_data = own_idx ? i_m_wb_data[63:32]     : i_m_wb_data[31:0];
    assign o_s_wb_sel  = own_idx ? i_m_wb_sel[7:4]        : i_m_wb_sel[3:0];

    // -----------------------------------------------------------------------
    // Master-side response
    // -----------------------------------------------------------------------
    always_comb begin
        o_m_wb_ack   = '0;
        o_m_wb_stall = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (owned && grant_q[k]) begin
                o_m_wb_ack[k]   = i_s_wb_ack;
                o_m_wb_stall[k] = i_s_wb_stall;
            end else begin
                o_m_wb_ack[k]   = tack_q[k];
                o_m_wb_stall[k] = i_m_wb_cyc[k];
            end
        end
    end

    assign o_m_wb_data = i_s_wb_data;
    assign o_grant     = grant_q;
    assign o_timeout   = timeout_q;

endmodule
